// File: rtl/ldpc_dec_sched.sv
// ldpc_dec_sched: frames an LLR stream into an LDPC decoder and frames its bit output.
// Define LDPC_SCHED_STAT_EN to add saturating frame/drop/timeout/max-iteration counters.
module ldpc_dec_sched #(
  parameter int D_WID   = 6,
  parameter int FRM_LEN = 9216,
  parameter int TMO_CYC = 65535
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [D_WID-1:0] data_in,
  input  logic             sync_in,
  input  logic             rate,
  input  logic [4:0]       max_iter,
  output logic             in_rdy,
  output logic [D_WID-1:0] dec_data,
  output logic             dec_sync,
  output logic             dec_rate,
  output logic [4:0]       dec_max_iter,
  input  logic             dec_busy,
  input  logic             dec_dout,
  input  logic             dec_sync_out,
  input  logic [4:0]       dec_num_iter,
  output logic             out_bit,
  output logic             out_vld,
  output logic             out_sof,
  output logic             out_eof,
  output logic [4:0]       last_iter,
  output logic             drop_p,
  output logic             pad_p,
  output logic             tmo_p
`ifdef LDPC_SCHED_STAT_EN
  ,
  output logic [15:0]      frm_cnt,
  output logic [15:0]      drop_cnt,
  output logic [15:0]      tmo_cnt,
  output logic [15:0]      maxit_cnt
`endif
);

  localparam int TW = $clog2(TMO_CYC + 1);
  localparam logic [13:0]   FRM_LAST = 14'(FRM_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
  localparam logic [12:0]   K0_LAST  = 13'd4607;
  localparam logic [12:0]   K1_LAST  = 13'd6911;

  typedef enum logic [1:0] {IDLE, FEED, WAIT, DRAIN} state_t;

  state_t           state_q;
  logic             sync_q;
  logic [13:0]      cnt_q;
  logic             pad_q;
  logic [12:0]      ocnt_q;
  logic [TW-1:0]    tmo_q;
  logic             rdy_q;
  logic [D_WID-1:0] ddata_q;
  logic             dsync_q;
  logic             drate_q;
  logic [4:0]       dmax_q;
  logic             obit_q;
  logic             ovld_q;
  logic             osof_q;
  logic             oeof_q;
  logic [4:0]       liter_q;
  logic             drop_q;
  logic             padp_q;
  logic             tmop_q;

  logic        sync_rise;
  logic        start;
  logic        drop_ev;
  logic [12:0] k_last;
  logic        eof_ev;
  logic        tmo_ev;

  assign sync_rise = sync_in & ~sync_q;
  assign start     = sync_rise && (state_q == IDLE) && !dec_busy;
  assign drop_ev   = sync_rise && !start;
  assign k_last    = drate_q ? K1_LAST : K0_LAST;
  assign eof_ev    = (state_q == DRAIN) && dec_sync_out && (ocnt_q == k_last);
  assign tmo_ev    = ((state_q == WAIT) || (state_q == DRAIN)) &&
                     !dec_sync_out && (tmo_q == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sync_q  <= sync_in;
      cnt_q   <= '0;
      pad_q   <= 1'b0;
      ocnt_q  <= '0;
      tmo_q   <= '0;
      rdy_q   <= 1'b1;
      ddata_q <= '0;
      dsync_q <= 1'b0;
      drate_q <= 1'b0;
      dmax_q  <= 5'd20;
      obit_q  <= 1'b0;
      ovld_q  <= 1'b0;
      osof_q  <= 1'b0;
      oeof_q  <= 1'b0;
      liter_q <= '0;
      drop_q  <= 1'b0;
      padp_q  <= 1'b0;
      tmop_q  <= 1'b0;
    end else begin
      sync_q  <= sync_in;
      ddata_q <= '0;
      dsync_q <= 1'b0;
      obit_q  <= 1'b0;
      ovld_q  <= 1'b0;
      osof_q  <= 1'b0;
      oeof_q  <= 1'b0;
      padp_q  <= 1'b0;
      tmop_q  <= 1'b0;
      drop_q  <= drop_ev;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= FEED;
            rdy_q   <= 1'b0;
            drate_q <= rate;
            dmax_q  <= max_iter;
            ddata_q <= data_in;
            dsync_q <= 1'b1;
            cnt_q   <= 14'd1;
            pad_q   <= 1'b0;
          end
        end
        FEED: begin
          dsync_q <= 1'b1;
          // once the burst ends early, the rest of the frame is erasures
          if (sync_in && !pad_q) begin
            ddata_q <= data_in;
          end else begin
            pad_q  <= 1'b1;
            padp_q <= !pad_q;
          end
          if (cnt_q == FRM_LAST) begin
            state_q <= WAIT;
            cnt_q   <= '0;
            tmo_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 14'd1;
          end
        end
        WAIT: begin
          if (dec_sync_out) begin
            state_q <= DRAIN;
            obit_q  <= dec_dout;
            ovld_q  <= 1'b1;
            osof_q  <= 1'b1;
            ocnt_q  <= 13'd1;
            tmo_q   <= '0;
          end else if (tmo_ev) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
            tmop_q  <= 1'b1;
            tmo_q   <= '0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        DRAIN: begin
          if (dec_sync_out) begin
            obit_q <= dec_dout;
            ovld_q <= 1'b1;
            tmo_q  <= '0;
            ocnt_q <= ocnt_q + 13'd1;
            if (eof_ev) begin
              oeof_q  <= 1'b1;
              liter_q <= dec_num_iter;
              state_q <= IDLE;
              rdy_q   <= 1'b1;
              ocnt_q  <= '0;
            end
          end else if (tmo_ev) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
            tmop_q  <= 1'b1;
            tmo_q   <= '0;
            ocnt_q  <= '0;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
      endcase
    end
  end

  assign in_rdy       = rdy_q;
  assign dec_data     = ddata_q;
  assign dec_sync     = dsync_q;
  assign dec_rate     = drate_q;
  assign dec_max_iter = dmax_q;
  assign out_bit      = obit_q;
  assign out_vld      = ovld_q;
  assign out_sof      = osof_q;
  assign out_eof      = oeof_q;
  assign last_iter    = liter_q;
  assign drop_p       = drop_q;
  assign pad_p        = padp_q;
  assign tmo_p        = tmop_q;

`ifdef LDPC_SCHED_STAT_EN
  logic [15:0] frm_q;
  logic [15:0] drp_q;
  logic [15:0] tmc_q;
  logic [15:0] mxi_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
    return (inc && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frm_q <= '0;
      drp_q <= '0;
      tmc_q <= '0;
      mxi_q <= '0;
    end else begin
      frm_q <= sat_inc(frm_q, eof_ev);
      drp_q <= sat_inc(drp_q, drop_ev);
      tmc_q <= sat_inc(tmc_q, tmo_ev);
      mxi_q <= sat_inc(mxi_q, eof_ev && (dec_num_iter == dmax_q));
    end
  end

  assign frm_cnt   = frm_q;
  assign drop_cnt  = drp_q;
  assign tmo_cnt   = tmc_q;
  assign maxit_cnt = mxi_q;
`endif

endmodule

// File: doc/ldpc_dec_sched.md
LDPC_DEC_SCHED -- requirements
Module: ldpc_dec_sched

Interface
REQ-001 Parameter D_WID, 6, soft-value (LLR) width.
REQ-002 Parameter FRM_LEN, 9216, codeword length in samples.
REQ-003 Parameter TMO_CYC, 65535, maximum idle cycles allowed while waiting for decoder output.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset_n  input  1  reset, synchronous and active-low.
REQ-006 data_in  input  D_WID  upstream LLR sample.
REQ-007 sync_in  input  1  upstream sample valid; a rising edge starts a frame.
REQ-008 rate  input  1  code rate (0 = 1/2, K=4608; 1 = 3/4, K=6912).
REQ-009 max_iter  input  5  iteration limit for the next frame.
REQ-010 in_rdy  output  1  high only in IDLE; scheduler accepts a new frame.
REQ-011 dec_data, dec_sync, dec_rate, dec_max_iter  output  D_WID/1/1/5  drive the decoder inputs.
REQ-012 dec_busy, dec_dout, dec_sync_out, dec_num_iter  input  1/1/1/5  decoder status and output.
REQ-013 out_bit, out_vld, out_sof, out_eof  output  1 each  decoded bit stream with frame markers.
REQ-014 last_iter  output  5  dec_num_iter captured on out_eof.
REQ-015 drop_p, pad_p, tmo_p  output  1 each  single-cycle event pulses.

Function
REQ-016 FSM states: IDLE, FEED, WAIT, DRAIN.
REQ-017 IDLE->FEED on a sync_in rising edge while dec_busy=0; rate and max_iter latched into dec_rate/dec_max_iter in that cycle and held until the next IDLE->FEED transition.
REQ-018 A sync_in rising edge in any state other than IDLE, or in IDLE with dec_busy=1, drops the whole burst: drop_p pulses once, nothing is forwarded, and the FSM is unaffected.
REQ-019 FEED: dec_data/dec_sync are data_in/1 registered, 1-cycle latency; the 14-bit sample counter runs from 0 to FRM_LEN-1.
REQ-020 sync_in low in FEED before FRM_LEN samples: remaining samples are padded with dec_data=0 (erasure) and dec_sync=1; pad_p pulses on the first pad cycle only.
REQ-021 sync_in staying high after FRM_LEN samples: excess samples are ignored and do not trigger drop_p.
REQ-022 FEED->WAIT when the counter reaches FRM_LEN-1; dec_sync is 0 on the next cycle.
REQ-023 WAIT->DRAIN on the first dec_sync_out=1.
REQ-024 DRAIN: out_bit/out_vld are dec_dout/dec_sync_out registered, 1-cycle latency; a 13-bit output counter runs.
REQ-025 out_sof marks output bit 0; out_eof marks bit K-1, with K set by the latched rate; last_iter updates on the out_eof cycle; DRAIN->IDLE after bit K-1.
REQ-026 dec_sync_out beyond K bits, or while in IDLE/FEED, is discarded (out_vld=0).
REQ-027 A timeout counter runs in WAIT and DRAIN, clears on each dec_sync_out, and saturates at TMO_CYC; on reaching TMO_CYC, tmo_p pulses and the FSM goes to IDLE with no out_eof.
REQ-028 in_rdy=1 in IDLE; a frame may start in the cycle after DRAIN->IDLE.

Reset
REQ-029 reset_n=0 at a clock edge: FSM to IDLE, all counters to 0, dec_rate=0, dec_max_iter=20; in_rdy=1 on the next cycle; all other outputs 0.
REQ-030 Reset mid-frame abandons the frame with no pulses; sync_in must fall and rise again to start a new frame.

Configuration
REQ-031 With macro LDPC_SCHED_STAT_EN defined: 16-bit outputs frm_cnt (frames ending in out_eof), drop_cnt, tmo_cnt, and maxit_cnt (frames with last_iter=dec_max_iter); all are saturating and cleared by reset.
REQ-032 Without LDPC_SCHED_STAT_EN: these ports and their counters do not exist; all other behaviour is identical.

Verification
REQ-033 Scenario: reset, rate=0, max_iter=20, 9216 contiguous samples -> dec_sync high for exactly 9216 cycles; 4608 out_vld bits; out_sof/out_eof once each; return to IDLE.
REQ-034 Scenario: rate=1 frame -> 6912 output bits; dec_rate=1 throughout; a change on rate mid-frame does not alter dec_rate.
REQ-035 Scenario: sync_in drops after 5000 samples -> 4216 zero pad samples; pad_p pulses once; dec_sync still high for 9216 cycles total.
REQ-036 Scenario: second burst starts during WAIT -> drop_p pulses once; no extra dec_sync; with LDPC_SCHED_STAT_EN, drop_cnt=1.
REQ-037 Scenario: decoder model stalls output (TMO_CYC=100) -> tmo_p pulses 100 cycles after the last dec_sync_out; FSM returns to IDLE; no out_eof.
REQ-038 Scenario: reset_n=0 for 1 cycle at sample 3000 -> dec_sync=0 next cycle; in_rdy=1; all pulses stay 0.
